// File: rtl/sp_ram_ctrl_if.sv
// Request/response bundle for sp_ram_ctrl: valid/ready request channel,
// unthrottled response channel and the clear-sweep status flag.
interface sp_ram_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
);
    localparam int BE_W = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              init_done;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
    );
endinterface

// File: rtl/sp_ram_ctrl.sv
// Single-port synchronous RAM behind a valid/ready request port: byte-enabled
// writes, fixed-latency in-order responses and an optional zeroing sweep after reset.
module sp_ram_ctrl #(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 6,
    parameter int DEPTH        = 64,
    parameter int RD_LAT       = 1,
    parameter int RDW_MODE     = 0,
    parameter int CLEAR_ON_RST = 1
) (
    input logic           clk,
    input logic           rst_n,
    sp_ram_ctrl_if.slave  bus
);
    localparam int BE_W = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_L  = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              ready;
    logic              clr_we;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              acc;
    logic              in_range;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [BE_W-1:0]   mem_be;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] merged_word;
    logic [DATA_W-1:0] rd_word;

    logic [DATA_W-1:0] rd1_q;
    logic              v1_q;
    logic              e1_q;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_READY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready   = 1'b0;
        clr_we  = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_we = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_L) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                ready = 1'b1;
            end
            default: begin
                state_d = ST_READY;
            end
        endcase
    end

    assign bus.req_ready = ready;
    assign bus.init_done = ready;

    // ---------------- array port ----------------
    assign acc      = bus.req_valid && ready && rst_n;
    assign in_range = {1'b0, bus.req_addr} < DEPTH_L;

    // The sweep owns the single port while clearing; requests are refused then.
    assign mem_we    = (clr_we && rst_n) || (acc && bus.req_we && in_range);
    assign mem_addr  = clr_we ? cnt_q : bus.req_addr;
    assign mem_be    = clr_we ? {BE_W{1'b1}} : bus.req_be;
    assign mem_wdata = clr_we ? '0 : bus.req_wdata;

    assign old_word = in_range ? mem_q[bus.req_addr] : '0;

    for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
        assign merged_word[8*gi +: 8] = bus.req_be[gi] ? bus.req_wdata[8*gi +: 8]
                                                       : old_word[8*gi +: 8];
    end

    always_comb begin
        rd_word = old_word;
        if (!in_range) begin
            rd_word = '0;
        end else if ((RDW_MODE != 0) && bus.req_we) begin
            rd_word = merged_word;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (mem_be[b]) begin
                    mem_q[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    // ---------------- response pipeline ----------------
    // Read register only loads on accepted requests so rsp_rdata holds between pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd1_q <= '0;
            v1_q  <= 1'b0;
            e1_q  <= 1'b0;
        end else begin
            v1_q <= acc;
            e1_q <= acc && !in_range;
            if (acc) begin
                rd1_q <= rd_word;
            end
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic [DATA_W-1:0] rd2_q;
        logic              v2_q;
        logic              e2_q;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rd2_q <= '0;
                v2_q  <= 1'b0;
                e2_q  <= 1'b0;
            end else begin
                v2_q <= v1_q;
                e2_q <= e1_q;
                if (v1_q) begin
                    rd2_q <= rd1_q;
                end
            end
        end

        assign bus.rsp_valid = v2_q;
        assign bus.rsp_rdata = rd2_q;
        assign bus.rsp_err   = e2_q;
    end else begin : g_lat1
        assign bus.rsp_valid = v1_q;
        assign bus.rsp_rdata = rd1_q;
        assign bus.rsp_err   = e1_q;
    end

endmodule
